garage_door_sequencer: RTL and testbench
========================================

# garage_door_sequencer

Sequencing controller for the garage-door motor pair. It arbitrates open/close requests from a wall button and a remote receiver. It sequences the UP_M/DN_M motor drives using the UP_Max/DN_Max limit switches, and reverses the door on obstruction with a mandatory motor dead-time. It also guards every travel with a watchdog and optionally auto-closes an open door. It sits between the already-synchronised door I/O and the motor driver stage.

## Interface
- TRAVEL_CYC, 1000: maximum cycles one motion state may last before FAULT (legal 2..65535)
- GAP_CYC, 4: dead-time cycles with both motors off before any motion start (legal 1..65535)
- AUTO_CLOSE_CYC, 5000: cycles in OPEN before automatic close (legal 2..65535; used only with AUTO_CLOSE_EN)
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- BTN_WALL  in  1  wall button, level, active-high
- BTN_REMOTE  in  1  remote button, level, active-high
- UP_Max  in  1  fully-open limit switch
- DN_Max  in  1  fully-closed limit switch
- OBST  in  1  obstruction beam broken
- FAULT_CLR  in  1  clears FAULT, level
- UP_M  out  1  raise motor drive
- DN_M  out  1  lower motor drive
- DOOR_OPEN  out  1  high in OPEN
- FAULT  out  1  high in FAULT
- SRC  out  2  last accepted requester: 00 none, 01 wall, 10 remote

## Operation
- States: STOPPED, GAP, OPENING, OPEN, CLOSING, CLOSED, FAULT. Moore outputs: UP_M=1 only in OPENING; DN_M=1 only in CLOSING; both never 1 together.
- Request detection: each button is rising-edge detected against a registered previous value. Previous-value registers reset to 1, so a button held through reset does not fire. cmd = wall_edge | remote_edge. On a simultaneous edge, wall wins: SRC=01. SRC updates only when cmd is acted on.
- dir register (UP/DOWN) records the last commanded motion; target register holds the GAP exit state.
- Timer: 16-bit, cleared on every state change, saturating increment otherwise.
- Transitions, highest priority first within a state:
  - OPENING/CLOSING: UP_Max&DN_Max -> FAULT; timer==TRAVEL_CYC-1 -> FAULT.
  - OPENING: UP_Max -> OPEN; cmd -> STOPPED.
  - CLOSING: DN_Max -> CLOSED; OBST -> GAP with target=OPENING (reversal, SRC unchanged); cmd -> STOPPED.
  - OPEN: cmd & !OBST -> GAP, target=CLOSING. cmd with OBST=1 is ignored.
  - CLOSED: cmd -> GAP, target=OPENING.
  - STOPPED: cmd -> GAP with target opposite of dir. If that target is CLOSING and OBST=1, cmd is ignored.
  - GAP: timer==GAP_CYC-1 -> target state; dir set to match target. Requests arriving in GAP are ignored.
  - FAULT: FAULT_CLR -> STOPPED with dir=DOWN, so the next cmd opens. All other inputs are ignored.
- Reset: state STOPPED, dir=DOWN, timer=0, SRC=00, UP_M=DN_M=DOOR_OPEN=FAULT=0.

## Timing
- Request edge sampled at rising edge k moves the state at edge k. New outputs are valid after edge k, giving a 1-cycle latency from input to output.
- Every motion start is preceded by exactly GAP_CYC cycles with UP_M=DN_M=0, including obstruction reversal.
- Limit switch or OBST sampled at edge k drops the motor drive after edge k. No extra cycle.
- Watchdog: the motion state persists at most TRAVEL_CYC cycles. FAULT is asserted from the TRAVEL_CYC+1-th cycle.
- RST asserted at any edge, including mid-motion, overrides everything. Outputs are 0 after that edge.
- Inputs are pre-synchronised and debounced upstream. This block adds no synchroniser.

## Configuration
- AUTO_CLOSE_EN defined: in OPEN, when timer==AUTO_CLOSE_CYC-1 and OBST=0, go to GAP with target=CLOSING; SRC is unchanged. With OBST=1 the timer is held at its current value until OBST clears.
- AUTO_CLOSE_EN undefined: OPEN is left only by cmd. No auto-close logic or parameter use is compiled in.

## Test plan
Parameters for all scenarios: TRAVEL_CYC=20, GAP_CYC=3, AUTO_CLOSE_CYC=10.
- Reset then wall pulse -> 3 cycles GAP with motors off, then UP_M=1. Assert UP_Max at motion cycle 8 -> UP_M=0, DOOR_OPEN=1, SRC=01.
- From OPEN, wall and remote rise on the same edge -> SRC=01. After 3 GAP cycles DN_M=1.
- CLOSING, OBST=1 at motion cycle 5 -> DN_M=0 next cycle, 3 off cycles, then UP_M=1.
- OPENING with no limit for 20 cycles -> FAULT=1, motors 0. Pulses ignored. FAULT_CLR then remote pulse -> GAP then UP_M=1.
- OPENING, remote pulse mid-travel -> STOPPED, motors 0. Next pulse -> GAP then DN_M=1.
- With AUTO_CLOSE_EN: OPEN for 10 cycles with OBST=0 -> GAP then DN_M=1. With OBST=1 held -> remains OPEN.

Source files
------------

// File: rtl/garage_door_sequencer_if.sv
// garage_door_sequencer_if: door I/O and motor-drive bundle between controller and its environment
interface garage_door_sequencer_if;
  logic BTN_WALL, BTN_REMOTE, UP_Max, DN_Max, OBST, FAULT_CLR;
  logic UP_M, DN_M, DOOR_OPEN, FAULT;
  logic [1:0] SRC;
  modport master (output BTN_WALL, BTN_REMOTE, UP_Max, DN_Max, OBST, FAULT_CLR,
                  input UP_M, DN_M, DOOR_OPEN, FAULT, SRC);
  modport slave (input BTN_WALL, BTN_REMOTE, UP_Max, DN_Max, OBST, FAULT_CLR,
                 output UP_M, DN_M, DOOR_OPEN, FAULT, SRC);
endinterface

// File: rtl/garage_door_sequencer.sv
// garage_door_sequencer: garage door motor sequencer with dead-time, reversal, watchdog and optional AUTO_CLOSE_EN auto-close
module garage_door_sequencer #(
  parameter int TRAVEL_CYC = 1000,
  parameter int GAP_CYC = 4
`ifdef AUTO_CLOSE_EN
  , parameter int AUTO_CLOSE_CYC = 5000
`endif
) (
  input logic CLK,
  input logic RST,
  garage_door_sequencer_if.slave io
);
  typedef enum logic [2:0] {S_STOPPED, S_GAP, S_OPENING, S_OPEN, S_CLOSING, S_CLOSED, S_FAULT} state_t;
  state_t state, state_n, target, target_n;
  logic dir, dir_n, wall_q, remote_q, wall_e, remote_e, cmd, accept, hold;
  logic [1:0] src, src_n;
  logic [15:0] timer;
  assign wall_e = io.BTN_WALL & ~wall_q;
  assign remote_e = io.BTN_REMOTE & ~remote_q;
  assign cmd = wall_e | remote_e;
`ifdef AUTO_CLOSE_EN
  assign hold = (state == S_OPEN) && io.OBST;
`else
  assign hold = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_STOPPED;
      target <= S_OPENING;
      dir <= 1'b0;
      src <= 2'b00;
      timer <= '0;
      wall_q <= 1'b1;
      remote_q <= 1'b1;
    end else begin
      state <= state_n;
      target <= target_n;
      dir <= dir_n;
      src <= src_n;
      wall_q <= io.BTN_WALL;
      remote_q <= io.BTN_REMOTE;
      timer <= (state_n != state) ? '0 : (hold || &timer) ? timer : timer + 16'd1;
    end
  end
  always_comb begin
    state_n = state;
    target_n = target;
    dir_n = dir;
    accept = 1'b0;
    case (state)
      S_OPENING:
        if ((io.UP_Max && io.DN_Max) || timer == 16'(TRAVEL_CYC - 1)) state_n = S_FAULT;
        else if (io.UP_Max) state_n = S_OPEN;
        else if (cmd) begin
          state_n = S_STOPPED;
          accept = 1'b1;
        end
      S_CLOSING:
        if ((io.UP_Max && io.DN_Max) || timer == 16'(TRAVEL_CYC - 1)) state_n = S_FAULT;
        else if (io.DN_Max) state_n = S_CLOSED;
        else if (io.OBST) begin
          state_n = S_GAP;
          target_n = S_OPENING;
        end else if (cmd) begin
          state_n = S_STOPPED;
          accept = 1'b1;
        end
      S_OPEN:
`ifdef AUTO_CLOSE_EN
        if (!io.OBST && (cmd || timer == 16'(AUTO_CLOSE_CYC - 1))) begin
          state_n = S_GAP;
          target_n = S_CLOSING;
          accept = cmd;
        end
`else
        if (cmd && !io.OBST) begin
          state_n = S_GAP;
          target_n = S_CLOSING;
          accept = 1'b1;
        end
`endif
      S_CLOSED:
        if (cmd) begin
          state_n = S_GAP;
          target_n = S_OPENING;
          accept = 1'b1;
        end
      S_STOPPED:
        if (cmd && !(dir && io.OBST)) begin
          state_n = S_GAP;
          target_n = dir ? S_CLOSING : S_OPENING;
          accept = 1'b1;
        end
      S_GAP:
        if (timer == 16'(GAP_CYC - 1)) begin
          state_n = target;
          dir_n = target == S_OPENING;
        end
      S_FAULT:
        if (io.FAULT_CLR) begin
          state_n = S_STOPPED;
          dir_n = 1'b0;
        end
      default: state_n = S_STOPPED;
    endcase
    src_n = accept ? (wall_e ? 2'b01 : 2'b10) : src;
  end
  assign io.UP_M = state == S_OPENING;
  assign io.DN_M = state == S_CLOSING;
  assign io.DOOR_OPEN = state == S_OPEN;
  assign io.FAULT = state == S_FAULT;
  assign io.SRC = src;
endmodule

// File: tb/tb_garage_door_sequencer.sv
// tb_garage_door_sequencer: scoreboard bench for the garage door sequencer
module tb_garage_door_sequencer;
  localparam logic [5:0] W = 6'b100000, R = 6'b010000, U = 6'b001000, D = 6'b000100, O = 6'b000010, C = 6'b000001;
  localparam logic [5:0] UPM = 6'b100000, DNM = 6'b010000, OPN = 6'b001000, FLT = 6'b000100, S1 = 6'b000001, S2 = 6'b000010;
  logic CLK, RST;
  int checks, errors, step;
  logic [5:0] exp_q[$];
  garage_door_sequencer_if io();
  garage_door_sequencer #(
    .TRAVEL_CYC(20),
    .GAP_CYC(3)
`ifdef AUTO_CLOSE_EN
    , .AUTO_CLOSE_CYC(10)
`endif
  ) dut (.CLK(CLK), .RST(RST), .io(io));
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      logic [5:0] e, got;
      e = exp_q.pop_front();
      got = {io.UP_M, io.DN_M, io.DOOR_OPEN, io.FAULT, io.SRC};
      checks++;
      step++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs step %0d: got %b expected %b", step, got, e);
      end
    end
  end
  task automatic cyc(input logic [5:0] in, input logic [5:0] exp, input int n = 1);
    for (int i = 0; i < n; i++) begin
      {io.BTN_WALL, io.BTN_REMOTE, io.UP_Max, io.DN_Max, io.OBST, io.FAULT_CLR} = in;
      exp_q.push_back(exp);
      @(posedge CLK);
      #1;
    end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    step = 0;
    RST = 1'b1;
    cyc(0, 0, 2);
    RST = 1'b0;
    cyc(0, 0);
    cyc(W, S1);
    cyc(0, S1, 2);
    cyc(0, UPM | S1, 7);
    cyc(U, OPN | S1, 2);
    cyc(U | W | R, S1);
    cyc(0, S1, 2);
    cyc(0, DNM | S1, 4);
    cyc(O, S1);
    cyc(0, S1, 2);
    cyc(0, UPM | S1, 20);
    cyc(0, FLT | S1);
    cyc(W, FLT | S1);
    cyc(R | U | D | O, FLT | S1);
    cyc(0, FLT | S1);
    cyc(C, S1);
    cyc(R, S2);
    cyc(0, S2, 2);
    cyc(0, UPM | S2, 3);
    cyc(R, S2);
    cyc(0, S2);
    cyc(R | O, S2);
    cyc(0, S2);
    cyc(R, S2);
    cyc(0, S2, 2);
    cyc(0, DNM | S2, 3);
    cyc(D, S2, 2);
    cyc(D | W | R, S1);
    cyc(0, S1, 2);
    cyc(0, UPM | S1, 2);
    cyc(U, OPN | S1);
`ifdef AUTO_CLOSE_EN
    cyc(U | O, OPN | S1, 4);
    cyc(U | O | R, OPN | S1);
    cyc(U | O, OPN | S1, 10);
    cyc(U, OPN | S1, 9);
    cyc(0, S1);
`else
    cyc(U, OPN | S1, 3);
    cyc(U | O | R, OPN | S1);
    cyc(U, OPN | S1, 30);
    cyc(W, S1);
`endif
    cyc(0, S1, 2);
    cyc(0, DNM | S1, 2);
    RST = 1'b1;
    cyc(W, 0, 2);
    RST = 1'b0;
    cyc(W, 0, 2);
    cyc(0, 0);
    cyc(R, S2);
    cyc(0, S2, 2);
    cyc(0, UPM | S2);
    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
